// File: rtl/hash_filter_pkg.sv
// Shared constants and the stage-1 entry layout for the hash difficulty filter
// and the validator, sized at the default hash and chunk widths.
package hash_filter_pkg;

    localparam logic MODE_LEADING  = 1'b0;
    localparam logic MODE_TRAILING = 1'b1;

    localparam int HASH_DATA_W  = 128;
    localparam int HASH_CHUNK_W = 16;
    localparam int HASH_CNT_W   = $clog2(HASH_DATA_W + 1);
    localparam int HASH_NCHUNK  = HASH_DATA_W / HASH_CHUNK_W;
    localparam int HASH_CZ_W    = $clog2(HASH_CHUNK_W + 1);

    typedef struct packed {
        logic [HASH_DATA_W-1:0]                 hash;
        logic [HASH_CNT_W-1:0]                  difficulty;
        logic                                   mode;
        logic [HASH_NCHUNK-1:0][HASH_CZ_W-1:0]  chunk_cnt;
        logic [HASH_NCHUNK-1:0]                 chunk_zero;
    } s1_entry_t;

endpackage

// File: rtl/hash_difficulty_filter_zero_count_chunk.sv
// Combinational leading-zero counter for one chunk; trailing-zero counts are
// obtained by feeding it the bit-reversed chunk.
module zero_count_chunk #(
    parameter int CHUNK_W = 16,
    parameter int ZW      = $clog2(CHUNK_W + 1)
) (
    input  logic [CHUNK_W-1:0] chunk_i,
    output logic [ZW-1:0]      zeros_o,
    output logic               all_zero_o
);

    // Scan upward so the highest set bit is the last writer.
    always_comb begin
        zeros_o = ZW'(CHUNK_W);
        for (int i = 0; i < CHUNK_W; i++) begin
            if (chunk_i[i]) begin
                zeros_o = ZW'(CHUNK_W - 1 - i);
            end else begin
                zeros_o = zeros_o;
            end
        end
    end

    assign all_zero_o = (chunk_i == {CHUNK_W{1'b0}});

endmodule

// File: rtl/hash_difficulty_filter.sv
// Two-stage hash difficulty filter with valid/ready on both sides.
// Optional pass/drop statistics counters are built when HASH_FILTER_STATS_EN is defined.
module hash_difficulty_filter
    import hash_filter_pkg::*;
#(
    parameter int DATA_W  = HASH_DATA_W,
    parameter int CHUNK_W = HASH_CHUNK_W,
    parameter int CNT_W   = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [DATA_W-1:0] i_hash,
    input  logic [CNT_W-1:0]  i_difficulty,
    input  logic              i_mode,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DATA_W-1:0] o_hash,
    output logic [CNT_W-1:0]  o_zeros,
    output logic              o_dropped
`ifdef HASH_FILTER_STATS_EN
    ,
    input  logic              i_stats_clr,
    output logic [31:0]       o_pass_cnt,
    output logic [31:0]       o_drop_cnt
`endif
);

    localparam int NCH = DATA_W / CHUNK_W;
    localparam int CZW = $clog2(CHUNK_W + 1);

    typedef struct packed {
        logic [DATA_W-1:0]          hash;
        logic [CNT_W-1:0]           difficulty;
        logic                       mode;
        logic [NCH-1:0][CZW-1:0]    chunk_cnt;
        logic [NCH-1:0]             chunk_zero;
    } s1_t;

    logic [NCH-1:0][CHUNK_W-1:0] ord_chunk_s;
    logic [NCH-1:0][CZW-1:0]     chunk_cnt_s;
    logic [NCH-1:0]              chunk_zero_s;

    s1_t               s1_q, s1_d;
    logic              s1_valid_q, s1_valid_d;
    logic              o_valid_q, o_valid_d;
    logic [DATA_W-1:0] o_hash_q, o_hash_d;
    logic [CNT_W-1:0]  o_zeros_q, o_zeros_d;
    logic              o_dropped_q, o_dropped_d;

    logic              s2_free_s, accept_s, advance_s, pass_s, walk_done_s;
    logic [CNT_W-1:0]  total_s;

    // Present chunks in scan order: MSB-first for leading, bit-reversed LSB-first for trailing.
    always_comb begin
        ord_chunk_s = {DATA_W{1'b0}};
        for (int c = 0; c < NCH; c++) begin
            for (int b = 0; b < CHUNK_W; b++) begin
                if (i_mode == MODE_TRAILING) begin
                    ord_chunk_s[c][b] = i_hash[c*CHUNK_W + CHUNK_W - 1 - b];
                end else begin
                    ord_chunk_s[c][b] = i_hash[DATA_W - 1 - c*CHUNK_W - (CHUNK_W - 1 - b)];
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chunk
        zero_count_chunk #(.CHUNK_W(CHUNK_W), .ZW(CZW)) u_zc (
            .chunk_i    (ord_chunk_s[g]),
            .zeros_o    (chunk_cnt_s[g]),
            .all_zero_o (chunk_zero_s[g])
        );
    end

    assign s2_free_s = !o_valid_q || o_ready;
    assign i_ready   = !s1_valid_q || s2_free_s;
    assign accept_s  = i_valid && i_ready;
    assign advance_s = s1_valid_q && s2_free_s;

    // Sum whole-zero chunks up to and including the first non-zero one.
    always_comb begin
        total_s     = {CNT_W{1'b0}};
        walk_done_s = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (!walk_done_s) begin
                total_s     = total_s + CNT_W'(s1_q.chunk_cnt[c]);
                walk_done_s = !s1_q.chunk_zero[c];
            end else begin
                total_s     = total_s;
            end
        end
        pass_s = (total_s >= s1_q.difficulty);
    end

    // Stage-1 next state: load on accept, empty when its entry moves on.
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (accept_s) begin
            s1_valid_d         = 1'b1;
            s1_d.hash          = i_hash;
            s1_d.difficulty    = i_difficulty;
            s1_d.mode          = i_mode;
            s1_d.chunk_cnt     = chunk_cnt_s;
            s1_d.chunk_zero    = chunk_zero_s;
        end else if (advance_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Output stage next state: failing entries pulse o_dropped instead of loading.
    always_comb begin
        o_valid_d   = o_valid_q;
        o_hash_d    = o_hash_q;
        o_zeros_d   = o_zeros_q;
        o_dropped_d = 1'b0;
        if (advance_s) begin
            o_valid_d   = pass_s;
            o_dropped_d = !pass_s;
            if (pass_s) begin
                o_hash_d  = s1_q.hash;
                o_zeros_d = total_s;
            end else begin
                o_hash_d  = o_hash_q;
                o_zeros_d = o_zeros_q;
            end
        end else if (s2_free_s) begin
            o_valid_d = 1'b0;
        end else begin
            o_valid_d = o_valid_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q        <= {$bits(s1_t){1'b0}};
            s1_valid_q  <= 1'b0;
            o_valid_q   <= 1'b0;
            o_hash_q    <= {DATA_W{1'b0}};
            o_zeros_q   <= {CNT_W{1'b0}};
            o_dropped_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            o_valid_q   <= o_valid_d;
            o_hash_q    <= o_hash_d;
            o_zeros_q   <= o_zeros_d;
            o_dropped_q <= o_dropped_d;
        end
    end

    assign o_valid   = o_valid_q;
    assign o_hash    = o_hash_q;
    assign o_zeros   = o_zeros_q;
    assign o_dropped = o_dropped_q;

`ifdef HASH_FILTER_STATS_EN
    logic [31:0] pass_cnt_q, pass_cnt_d, drop_cnt_q, drop_cnt_d;

    // Saturating counters; clear has priority over a coincident increment.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (i_stats_clr) begin
            pass_cnt_d = 32'd0;
            drop_cnt_d = 32'd0;
        end else begin
            if (o_valid_q && o_ready && (pass_cnt_q != 32'hFFFF_FFFF)) begin
                pass_cnt_d = pass_cnt_q + 32'd1;
            end else begin
                pass_cnt_d = pass_cnt_q;
            end
            if (o_dropped_d && (drop_cnt_q != 32'hFFFF_FFFF)) begin
                drop_cnt_d = drop_cnt_q + 32'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_cnt_q <= 32'd0;
            drop_cnt_q <= 32'd0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_pass_cnt = pass_cnt_q;
    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_hash_difficulty_filter.sv
// Scoreboard bench for hash_difficulty_filter: directed stimulus pushes expected
// outcomes, a negedge monitor pops them as outputs and drop pulses appear.
module tb_hash_difficulty_filter;

    localparam int DW = 128;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready;
    logic [DW-1:0] i_hash = '0;
    logic [NW-1:0] i_difficulty = '0;
    logic          i_mode = 1'b0;
    logic          o_valid;
    logic          o_ready = 1'b1;
    logic [DW-1:0] o_hash;
    logic [NW-1:0] o_zeros;
    logic          o_dropped;
`ifdef HASH_FILTER_STATS_EN
    logic          i_stats_clr = 1'b0;
    logic [31:0]   o_pass_cnt;
    logic [31:0]   o_drop_cnt;
`endif

    hash_difficulty_filter dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .i_hash       (i_hash),
        .i_difficulty (i_difficulty),
        .i_mode       (i_mode),
        .o_valid      (o_valid),
        .o_ready      (o_ready),
        .o_hash       (o_hash),
        .o_zeros      (o_zeros),
        .o_dropped    (o_dropped)
`ifdef HASH_FILTER_STATS_EN
        ,
        .i_stats_clr  (i_stats_clr),
        .o_pass_cnt   (o_pass_cnt),
        .o_drop_cnt   (o_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] hash;
        logic [NW-1:0] zeros;
        logic          pass;
        logic          lat;
        int            acc;
    } exp_t;

    typedef struct {
        logic [DW-1:0] hash;
        logic [NW-1:0] diff;
        logic          mode;
        logic          pass;
        logic [NW-1:0] zeros;
    } vec_t;

    exp_t q[$];
    vec_t vt[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_h(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic add(input logic [DW-1:0] h, input logic [NW-1:0] d, input logic m,
                       input logic p, input logic [NW-1:0] z);
        vec_t v;
        v.hash = h; v.diff = d; v.mode = m; v.pass = p; v.zeros = z;
        vt.push_back(v);
    endtask

    task automatic send(input logic [DW-1:0] h, input logic [NW-1:0] d, input logic m,
                        input logic p, input logic [NW-1:0] z, input logic lat, output int acc);
        int   n;
        exp_t e;
        i_valid = 1'b1; i_hash = h; i_difficulty = d; i_mode = m;
        n = 0;
        @(negedge clk);
        while (!i_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!i_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got i_ready=0 want 1 for hash %h", h);
            i_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            e.hash = h; e.zeros = z; e.pass = p; e.lat = lat; e.acc = acc;
            q.push_back(e);
        end
    endtask

    // Monitor: drop pulses refer to the previous edge, transfers to the next one.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (o_dropped) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL drop_unexpected: got drop pulse want none");
                end else begin
                    e = q.pop_front();
                    chk_i("drop_outcome", 0, int'(e.pass));
                    if (e.lat) chk_i("drop_latency", cyc, e.acc + 1);
                end
            end
            if (o_valid && o_ready) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out_unexpected: got hash %h want none", o_hash);
                end else begin
                    e = q.pop_front();
                    chk_i("out_outcome", 1, int'(e.pass));
                    chk_h("out_hash", o_hash, e.hash);
                    chk_i("out_zeros", int'(o_zeros), int'(e.zeros));
                    if (e.lat) chk_i("out_latency", cyc + 1, e.acc + 2);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            acc, prev;
        logic [DW-1:0] one;
        logic [DW-1:0] hold_h [3];
        one = 128'h1;
        hold_h[0] = 128'h100; hold_h[1] = 128'h200; hold_h[2] = 128'h400;

        // hash, difficulty, mode, pass, zeros
        add(128'h00FF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 8'd8,   1'b0, 1'b1, 8'd8);
        add(128'h01FF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 8'd8,   1'b0, 1'b0, 8'd7);
        add(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF0, 8'd4,   1'b1, 1'b1, 8'd4);
        add(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF8, 8'd4,   1'b1, 1'b0, 8'd3);
        add(128'h0,                                      8'd128, 1'b0, 1'b1, 8'd128);
        add(128'h0,                                      8'd129, 1'b0, 1'b0, 8'd128);
        add(128'h0,                                      8'd128, 1'b1, 1'b1, 8'd128);
        add(128'h8000_0000_0000_0000_0000_0000_0000_0000, 8'd0,   1'b0, 1'b1, 8'd0);
        add(128'h1,                                      8'd0,   1'b1, 1'b1, 8'd0);
        add(128'h0000_0000_0001_0000_0000_0000_0000_0000, 8'd47,  1'b0, 1'b1, 8'd47);
        add(128'h0000_0000_0001_0000_0000_0000_0000_0000, 8'd48,  1'b0, 1'b0, 8'd47);
        add(128'h8000_0000_0000_0000_0000_0000_0000_0000, 8'd127, 1'b1, 1'b1, 8'd127);
        add(128'h0000_0000_0000_0000_0000_0000_0004_0000, 8'd18,  1'b1, 1'b1, 8'd18);
        add(128'h0,                                      8'd200, 1'b1, 1'b0, 8'd128);
        add(128'h1,                                      8'd0,   1'b0, 1'b1, 8'd127);
        add(128'h1,                                      8'd128, 1'b0, 1'b0, 8'd127);

        // Reset state
        repeat (3) @(negedge clk);
        chk_i("rst_o_valid", int'(o_valid), 0);
        chk_i("rst_o_dropped", int'(o_dropped), 0);
        chk_h("rst_o_hash", o_hash, 128'h0);
        chk_i("rst_o_zeros", int'(o_zeros), 0);
        chk_i("rst_i_ready", int'(i_ready), 1);
        @(posedge clk); #1;
        rst = 1'b1;

        // Directed vectors, streamed with o_ready high
        foreach (vt[k]) send(vt[k].hash, vt[k].diff, vt[k].mode, vt[k].pass, vt[k].zeros, 1'b1, acc);
        i_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk_i("directed_drained", q.size(), 0);
`ifdef HASH_FILTER_STATS_EN
        chk_i("stats_pass_directed", int'(o_pass_cnt), 10);
        chk_i("stats_drop_directed", int'(o_drop_cnt), 6);
        @(posedge clk); #1; i_stats_clr = 1'b1;
        @(posedge clk); #1; i_stats_clr = 1'b0;
        chk_i("stats_pass_clr", int'(o_pass_cnt), 0);
        chk_i("stats_drop_clr", int'(o_drop_cnt), 0);
`endif

        // Back-to-back: 16 passing hashes, difficulty equal to their zero count
        @(posedge clk); #1;
        prev = 0;
        for (int k = 0; k < 16; k++) begin
            send(one << (7 * k), NW'(127 - 7 * k), 1'b0, 1'b1, NW'(127 - 7 * k), 1'b1, acc);
            if (k > 0) chk_i("b2b_accept_cycle", acc, prev + 1);
            prev = acc;
        end
        i_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk_i("b2b_drained", q.size(), 0);

        // Backpressure: three passing hashes offered with o_ready low
        @(posedge clk); #1;
        o_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 3; k++) send(hold_h[k], NW'(8 + k), 1'b1, 1'b1, NW'(8 + k), 1'b0, acc);
                i_valid = 1'b0;
            end
            begin
                repeat (8) @(negedge clk);
                chk_i("hold_o_valid", int'(o_valid), 1);
                chk_h("hold_o_hash", o_hash, 128'h100);
                chk_i("hold_o_zeros", int'(o_zeros), 8);
                chk_i("hold_i_ready", int'(i_ready), 0);
                repeat (3) @(negedge clk);
                chk_h("hold_o_hash_later", o_hash, 128'h100);
                @(posedge clk); #1;
                o_ready = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        chk_i("hold_drained", q.size(), 0);
`ifdef HASH_FILTER_STATS_EN
        chk_i("stats_pass_after_hold", int'(o_pass_cnt), 19);
        chk_i("stats_drop_after_hold", int'(o_drop_cnt), 0);
`endif

        // Reset with two hashes in flight
        @(posedge clk); #1;
        send(128'hDEAD, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, acc);
        send(128'hBEEF, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, acc);
        i_valid = 1'b0;
        chk_i("pre_rst_o_valid", int'(o_valid), 1);
        #2;
        rst = 1'b0;
        q.delete();
        #1;
        chk_i("async_rst_o_valid", int'(o_valid), 0);
        chk_h("async_rst_o_hash", o_hash, 128'h0);
        chk_i("async_rst_o_zeros", int'(o_zeros), 0);
`ifdef HASH_FILTER_STATS_EN
        chk_i("rst_stats_pass", int'(o_pass_cnt), 0);
        chk_i("rst_stats_drop", int'(o_drop_cnt), 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk_i("post_rst_o_valid", int'(o_valid), 0);
        chk_i("post_rst_o_dropped", int'(o_dropped), 0);
        chk_i("post_rst_queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
